// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader_pkg
// Description : Shared defaults, skid-buffer sizing and FSM state encoding
//               for the FIFO reader.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 6;
  localparam int unsigned CNT_WIDTH_DEFAULT  = 8;

  // Two entries cover the pop-to-data latency so reads can stream back to back.
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry in-order buffer. Holds words returned by the FIFO
//               until the downstream consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      push_data,
  output logic [WIDTH-1:0]      pop_data,
  output logic                  empty,
  output logic                  full,
  output logic [SKID_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [SKID_DEPTH];
  logic [WIDTH-1:0]      mem_d [SKID_DEPTH];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == SKID_CNT_W'(SKID_DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next-state: a push into a full buffer is only taken when a pop frees a slot.
  always_comb begin
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q + SKID_CNT_W'(do_push) - SKID_CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
    end
  end

  // Storage and pointer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_reader
// Description : Pulls words from a registered-flag FIFO and streams them
//               downstream with valid/ready, counting delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic                  Fifo_Empty,
  input  logic                  Almost_Empty,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_out,
  input  logic                  ready_in,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic                  lag_q, lag_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic                  buf_empty;
  logic                  buf_full;
  logic [SKID_CNT_W-1:0] buf_count;
  logic                  xfer;
  logic [SKID_CNT_W-1:0] words_kept;

  skid_buffer #(
    .WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (reset_L),
    .push      (inflight_q),
    .pop       (xfer),
    .push_data (Fifo_Data_out),
    .pop_data  (data_out),
    .empty     (buf_empty),
    .full      (buf_full),
    .count     (buf_count)
  );

  assign valid_out = !buf_empty;
  assign xfer      = valid_out && ready_in;
  assign rd_count  = rd_count_q;
  assign busy      = (state_q != ST_IDLE);

  // Pop credit and next-state logic. Buffered words are counted after this
  // cycle's transfer so a steady stream sustains one pop per cycle.
  always_comb begin
    state_d    = state_q;
    words_kept = buf_count - SKID_CNT_W'(xfer) + SKID_CNT_W'(inflight_q);
    pop        = (state_q == ST_ACTIVE) && !Fifo_Empty && !lag_q
                 && (words_kept < SKID_CNT_W'(SKID_DEPTH))
                 && !(buf_full && !xfer);
    // The FIFO's empty flag lags a pop of its last word by one cycle.
    lag_d      = pop && Almost_Empty;
    inflight_d = pop;
    rd_count_d = rd_count_q + CNT_WIDTH'(xfer);
    unique case (state_q)
      ST_IDLE:   if (enable) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!enable) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (enable) begin
          state_d = ST_ACTIVE;
        end else if (!inflight_q && buf_empty) begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Control state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      inflight_q <= 1'b0;
      lag_q      <= 1'b0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      lag_q      <= lag_d;
      rd_count_q <= rd_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_reader
// Description : Directed bench for fifo_reader with an upstream FIFO model
//               and an in-order scoreboard of expected delivered words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

  localparam int DW = 6;
  localparam int CW = 8;

  logic          clk;
  logic          reset_L;
  logic          enable;
  logic          Fifo_Empty;
  logic          Almost_Empty;
  logic [DW-1:0] Fifo_Data_out;
  logic          ready_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] rd_count;
  logic          busy;

  fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .enable        (enable),
    .Fifo_Empty    (Fifo_Empty),
    .Almost_Empty  (Almost_Empty),
    .Fifo_Data_out (Fifo_Data_out),
    .ready_in      (ready_in),
    .pop           (pop),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .rd_count      (rd_count),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] fifo_m [$];
  logic [DW-1:0] sb [$];

  logic          s_pop, s_valid, s_busy;
  logic [DW-1:0] s_data;
  int            run_len, best_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_m.push_back(w);
    sb.push_back(w);
    Fifo_Empty   = 1'b0;
    Almost_Empty = (fifo_m.size() == 1);
  endtask

  // One clock: sample at the falling edge, then model the FIFO after the rise.
  task automatic tick();
    logic p;
    logic x;
    int   old_size;
    @(negedge clk);
    p       = pop;
    x       = valid_out && ready_in;
    s_pop   = pop;
    s_valid = valid_out;
    s_busy  = busy;
    s_data  = data_out;
    if (x) begin
      run_len++;
      if (run_len > best_run) best_run = run_len;
      n_total++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL sb_underflow observed=0x%0h expected=none", data_out);
      if (sb.size() != 0) chk("data_order", 32'(data_out), 32'(sb.pop_front()));
    end else begin
      run_len = 0;
    end
    if (p) begin
      n_total++;
      assert (fifo_m.size() != 0) n_pass++;
      else $error("FAIL pop_on_empty observed=1 expected=0");
    end
    @(posedge clk);
    #1;
    if (p) begin
      old_size = fifo_m.size();
      if (old_size > 0) Fifo_Data_out = fifo_m.pop_front();
      Fifo_Empty = (old_size == 0);
    end else begin
      Fifo_Empty = (fifo_m.size() == 0);
    end
    Almost_Empty = (fifo_m.size() == 1);
  endtask

  initial begin
    int            npop;
    logic [6:0]    ep;
    logic [6:0]    ev;
    reset_L       = 1'b0;
    enable        = 1'b0;
    Fifo_Empty    = 1'b1;
    Almost_Empty  = 1'b0;
    Fifo_Data_out = '0;
    ready_in      = 1'b1;
    run_len       = 0;
    best_run      = 0;

    // Reset state
    #12;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_count", 32'(rd_count), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // Three-word burst: pops cycles 1-3, valid cycles 3-5
    push_word(6'h01); push_word(6'h02); push_word(6'h03);
    enable = 1'b1;
    ep = 7'b0001110;
    ev = 7'b0111000;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("burst_pop_c%0d", i), 32'(s_pop), 32'(ep[i]));
      chk($sformatf("burst_valid_c%0d", i), 32'(s_valid), 32'(ev[i]));
    end
    chk("burst_count", 32'(rd_count), 3);

    // Single word: exactly one pop, blocked next cycle despite stale empty flag
    push_word(6'h2A);
    tick();
    chk("single_pop", 32'(s_pop), 1);
    tick();
    chk("single_lag_block", 32'(s_pop), 0);
    for (int i = 0; i < 4; i++) tick();
    chk("single_count", 32'(rd_count), 4);
    chk("single_delivered", 32'(sb.size()), 0);

    // Async reset while valid_out=1 and rd_count=5
    push_word(6'h11); push_word(6'h12); push_word(6'h13);
    for (int i = 0; i < 10 && rd_count != 8'd5; i++) tick();
    chk("pre_rst_count", 32'(rd_count), 5);
    chk("pre_rst_valid", 32'(valid_out), 1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_out), 0);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_count", 32'(rd_count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_pop", 32'(pop), 0);
    fifo_m.delete();
    sb.delete();
    Fifo_Empty   = 1'b1;
    Almost_Empty = 1'b0;
    @(posedge clk); #1;
    reset_L = 1'b1;
    tick();
    chk("post_rst_idle_busy", 32'(s_busy), 0);
    chk("post_rst_idle_pop", 32'(s_pop), 0);
    tick();
    chk("post_rst_active", 32'(s_busy), 1);

    // Backpressure: ready_in low for 4 cycles
    ready_in = 1'b0;
    for (int i = 0; i < 6; i++) push_word(6'(6'h20 + i));
    npop = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_pop) npop++;
      if (i >= 2) begin
        chk($sformatf("hold_valid_c%0d", i), 32'(s_valid), 1);
        chk($sformatf("hold_data_c%0d", i), 32'(s_data), 32'(sb[0]));
      end
    end
    chk("hold_pops", 32'(npop), 2);
    chk("hold_pop_stopped", 32'(s_pop), 0);
    ready_in = 1'b1;
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk("hold_all_delivered", 32'(sb.size()), 0);
    chk("hold_count", 32'(rd_count), 6);

    // enable dropped after a pop: drain in-flight word, no new pops
    push_word(6'h31); push_word(6'h32); push_word(6'h33);
    tick();
    enable = 1'b0;
    tick();
    npop = 0;
    s_busy = 1'b1;
    for (int i = 0; i < 20 && s_busy; i++) begin
      tick();
      if (s_pop) npop++;
    end
    chk("drain_no_pop", 32'(npop), 0);
    chk("drain_idle", 32'(s_busy), 0);
    chk("drain_fifo_left", 32'(fifo_m.size()), 1);
    chk("drain_pending", 32'(sb.size()), 1);
    chk("drain_count", 32'(rd_count), 8);

    // Long stream: one word per cycle, rd_count reaches 0xFF then wraps
    for (int i = 0; i < 246; i++) push_word(6'(i));
    enable   = 1'b1;
    best_run = 0;
    for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
    chk("stream_delivered", 32'(sb.size()), 0);
    chk("stream_run", 32'(best_run), 247);
    chk("count_ff", 32'(rd_count), 32'hFF);
    push_word(6'h3F);
    for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
    chk("count_wrap", 32'(rd_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
